// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared encodings and control-word layout for the multi-cycle CPU controller.
package cpu_ctrl_pkg;
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_ALU_WB   = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_READ = 4'd5,
      S_MEM_WB   = 4'd6,
      S_MEM_WRITE= 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_IMM_EXEC = 4'd10,
      S_IMM_WB   = 4'd11,
      S_HALT     = 4'd12
   } state_t;
   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] OP_LW    = 4'b0001;
   localparam logic [3:0] OP_SW    = 4'b0010;
   localparam logic [3:0] OP_BEQ   = 4'b0011;
   localparam logic [3:0] OP_J     = 4'b0100;
   localparam logic [3:0] OP_ADDI  = 4'b0101;
   localparam logic [3:0] OP_HLT   = 4'b1111;
   localparam logic [1:0] ALU_RTYPE = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_ADD   = 2'b10;
   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_ONE  = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] PCSRC_ALU  = 2'b00;
   localparam logic [1:0] PCSRC_OUT  = 2'b01;
   localparam logic [1:0] PCSRC_JUMP = 2'b10;
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       reg_dst;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;
endpackage

// File: rtl/multicycle_ctrl_decode.sv
// multicycle_ctrl_decode: maps the controller state to the datapath control word.
module multicycle_ctrl_decode
   import cpu_ctrl_pkg::*;
(
   input  state_t state_i,
   input  logic   mem_ready_i,
   output ctrl_t  ctrl_o
);
   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.mem_read  = 1'b1;
            ctrl_o.alu_src_b = SRCB_ONE;
            ctrl_o.alu_op    = ALU_ADD;
            ctrl_o.ir_write  = mem_ready_i;
            ctrl_o.pc_write  = mem_ready_i;
         end
         S_DECODE: begin
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALU_ADD;
         end
         S_EXEC_R: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_op    = ALU_RTYPE;
         end
         S_ALU_WB: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.reg_dst   = 1'b1;
         end
         S_MEM_ADDR, S_IMM_EXEC: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALU_ADD;
         end
         S_MEM_READ: begin
            ctrl_o.mem_read = 1'b1;
            ctrl_o.i_or_d   = 1'b1;
         end
         S_MEM_WRITE: begin
            ctrl_o.mem_write = 1'b1;
            ctrl_o.i_or_d    = 1'b1;
         end
         S_MEM_WB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
         end
         S_IMM_WB: ctrl_o.reg_write = 1'b1;
         S_BRANCH: begin
            ctrl_o.alu_src_a     = 1'b1;
            ctrl_o.alu_op        = ALU_SUB;
            ctrl_o.pc_write_cond = 1'b1;
            ctrl_o.pc_source     = PCSRC_OUT;
         end
         S_JUMP: begin
            ctrl_o.pc_write  = 1'b1;
            ctrl_o.pc_source = PCSRC_JUMP;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main sequencing FSM of the multi-cycle CPU; owns state and sticky flags,
// delegates the per-state control word to multicycle_ctrl_decode.
module multicycle_control
   import cpu_ctrl_pkg::*;
#(
   parameter int OPW = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [OPW-1:0] opcode,
   input  logic           zero,
   input  logic           mem_ready,
   output logic           pc_write,
   output logic           pc_write_cond,
   output logic           i_or_d,
   output logic           mem_read,
   output logic           mem_write,
   output logic           ir_write,
   output logic           mem_to_reg,
   output logic           reg_write,
   output logic           reg_dst,
   output logic           alu_src_a,
   output logic [1:0]     alu_src_b,
   output logic [1:0]     alu_op,
   output logic [1:0]     pc_source,
   output logic           halted,
   output logic           illegal,
   output logic [3:0]     state
);
   state_t state_q, state_d;
   logic   is_lw_q, is_lw_d, halted_q, halted_d, illegal_q, illegal_d;
   ctrl_t  ctrl;
   logic   unused_zero;
   assign unused_zero = zero;
   always_comb begin
      state_d   = state_q;
      is_lw_d   = is_lw_q;
      illegal_d = illegal_q;
      case (state_q)
         S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            is_lw_d = (opcode == OPW'(OP_LW));
            if (opcode == OPW'(OP_RTYPE))                                state_d = S_EXEC_R;
            else if (opcode == OPW'(OP_LW) || opcode == OPW'(OP_SW))     state_d = S_MEM_ADDR;
            else if (opcode == OPW'(OP_BEQ))                             state_d = S_BRANCH;
            else if (opcode == OPW'(OP_J))                               state_d = S_JUMP;
            else if (opcode == OPW'(OP_ADDI))                            state_d = S_IMM_EXEC;
            else begin
               state_d   = S_HALT;
               illegal_d = illegal_q | (opcode != OPW'(OP_HLT));
            end
         end
         S_EXEC_R:    state_d = S_ALU_WB;
         S_MEM_ADDR:  state_d = is_lw_q ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
         S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
         S_IMM_EXEC:  state_d = S_IMM_WB;
         S_HALT:      state_d = S_HALT;
         default:     state_d = S_FETCH;
      endcase
      halted_d = halted_q | (state_d == S_HALT);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         is_lw_q   <= 1'b0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         is_lw_q   <= is_lw_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
      end
   end
   // Mealy fetch enables are masked while reset is held so the reset image is the idle FETCH word.
   multicycle_ctrl_decode u_decode (
      .state_i     (state_q),
      .mem_ready_i (mem_ready & ~reset),
      .ctrl_o      (ctrl)
   );
   assign pc_write      = ctrl.pc_write;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign i_or_d        = ctrl.i_or_d;
   assign mem_read      = ctrl.mem_read;
   assign mem_write     = ctrl.mem_write;
   assign ir_write      = ctrl.ir_write;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign reg_write     = ctrl.reg_write;
   assign reg_dst       = ctrl.reg_dst;
   assign alu_src_a     = ctrl.alu_src_a;
   assign alu_src_b     = ctrl.alu_src_b;
   assign alu_op        = ctrl.alu_op;
   assign pc_source     = ctrl.pc_source;
   assign halted        = halted_q;
   assign illegal       = illegal_q;
   assign state         = state_q;
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle CPU datapath. Sequences instruction fetch, decode, execute, memory access and write-back over several clocks, driving the register, memory, PC and mux enables. Produces the 2-bit `alu_op` consumed by the ALU control decoder. Sits between the instruction register opcode field and every datapath enable; memory accesses are stalled by a ready handshake.

## Interface
Parameters:
- `OPW`, 4: opcode width (instruction bits [15:12]).

Ports:
- `clk` input 1: single system clock, rising edge.
- `reset` input 1: asynchronous, active-high; forces state FETCH and clears `halted`/`illegal`.
- `opcode` input OPW: IR[15:12], valid from DECODE onward.
- `zero` input 1: ALU zero flag (gated by `pc_write_cond` externally).
- `mem_ready` input 1: memory completes current read/write this cycle.
- `pc_write`, `pc_write_cond`, `i_or_d`, `mem_read`, `mem_write`, `ir_write`, `mem_to_reg`, `reg_write`, `reg_dst`, `alu_src_a` output 1: datapath enables/selects.
- `alu_src_b` output 2: 00 reg B, 01 constant 1, 10 sign-extended imm.
- `alu_op` output 2: 00 R-type (Function field decides), 01 subtract, 10 add.
- `pc_source` output 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `halted` output 1: sticky, set on HLT.
- `illegal` output 1: sticky, set on undefined opcode.
- `state` output 4: current state encoding, debug.

## Operation
- Opcodes: 0000 R-type, 0001 LW, 0010 SW, 0011 BEQ, 0100 J, 0101 ADDI, 1111 HLT; all others illegal.
- States and transitions:
  - FETCH → DECODE when `mem_ready`, else hold.
  - DECODE → EXEC_R / MEM_ADDR / BRANCH / JUMP / IMM_EXEC / HALT by opcode. Illegal opcode → HALT with `illegal`=1.
  - EXEC_R → ALU_WB → FETCH.
  - MEM_ADDR → MEM_READ (LW) or MEM_WRITE (SW).
  - MEM_READ → MEM_WB when `mem_ready`, else hold. MEM_WB → FETCH.
  - MEM_WRITE → FETCH when `mem_ready`, else hold.
  - BRANCH → FETCH; JUMP → FETCH.
  - IMM_EXEC → IMM_WB → FETCH.
  - HALT: absorbing until `reset`.
- Outputs per state (all unlisted = 0):
  - FETCH: `mem_read`=1, `alu_src_b`=01, `alu_op`=10. `ir_write` and `pc_write` = `mem_ready` (the only Mealy terms).
  - DECODE: `alu_src_b`=10, `alu_op`=10; branch target into ALUOut.
  - EXEC_R: `alu_src_a`=1, `alu_op`=00.
  - ALU_WB: `reg_write`=1, `reg_dst`=1.
  - MEM_ADDR, IMM_EXEC: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=10.
  - MEM_READ: `mem_read`=1, `i_or_d`=1.
  - MEM_WRITE: `mem_write`=1, `i_or_d`=1.
  - MEM_WB: `reg_write`=1, `mem_to_reg`=1.
  - IMM_WB: `reg_write`=1.
  - BRANCH: `alu_src_a`=1, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01.
  - JUMP: `pc_write`=1, `pc_source`=10.
- `halted`=1 in HALT; `illegal` sticky until reset.

## Timing
- Reset value of every output is the FETCH decode with `mem_ready`=0: `mem_read`=1, `alu_src_b`=01, `alu_op`=10, all else 0; `state`=FETCH.
- Cycles per instruction at zero wait: R 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4. Each `mem_ready`-low cycle in FETCH/MEM_READ/MEM_WRITE adds 1.
- Memory request held stable while waiting; `ir_write`/`pc_write` never assert before `mem_ready`.
- `reset` mid-instruction aborts immediately (asynchronous); no partial write-back follows.
- `opcode` is sampled only in DECODE; changes elsewhere are ignored.

## Structure
- Package `cpu_ctrl_pkg`: state encodings (4-bit), opcode constants, ALUOp constants (00/01/10), `alu_src_b`/`pc_source` select constants.
- Sub-module `multicycle_ctrl_decode`: combinational state → control word; FSM register and next-state logic stay in `multicycle_control`.

## Test plan
- Reset asserted mid-EXEC_R → `state`=FETCH same cycle, `reg_write`=0, `mem_read`=1.
- R-type (`opcode`=0000), `mem_ready`=1 → states FETCH, DECODE, EXEC_R, ALU_WB; `alu_op`=00 in EXEC_R; `reg_write`=`reg_dst`=1 exactly one cycle.
- LW with `mem_ready` low 2 cycles in MEM_READ → 7 cycles total; `mem_read`=`i_or_d`=1 held 3 cycles; `mem_to_reg`=1 in MEM_WB.
- BEQ (0011) → `alu_op`=01 and `pc_write_cond`=1 in cycle 3; J (0100) → `pc_write`=1, `pc_source`=10 in cycle 3.
- `opcode`=1010 → HALT, `illegal`=1, `halted`=1, no enables asserted; persists until reset.
- FETCH with `mem_ready`=0 for 3 cycles → `ir_write`=`pc_write`=0 throughout; both assert in the cycle `mem_ready` rises.
